// File: rtl/mem_access_stage.sv
// Memory-access stage with MEM/WB register.
// Turns EX/MEM load/store control into single-outstanding req/ack bus
// transactions, aligns store lanes, extracts/extends load data, stalls the
// upstream pipeline until ack, and registers results for write-back.
// Ports:
//   clk_i, rst_i            clock, synchronous active-low reset
//   valid_i .. Size_i       EX/MEM fields (address/result, store data, rd, controls)
//   stall_o                 combinational hold request to EX/MEM and earlier
//   mem_*_o / mem_*_i       data-memory bus (req, we, addr, wdata, wstrb / rdata, ack)
//   valid_o .. misalign_o   MEM/WB register outputs
module mem_access_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] ALU_Res_i,
  input  logic [31:0] Write_Data_i,
  input  logic [4:0]  RdAddr_i,
  input  logic        MemToReg_i,
  input  logic        MemWrite_i,
  input  logic        RegWrite_i,
  input  logic        ExtOp_i,
  input  logic [1:0]  Size_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        valid_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic [31:0] ALU_Res_o,
  output logic [31:0] Mem_Data_o,
  output logic [4:0]  RdAddr_o,
  output logic        misalign_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned BW = 4;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            req_q, we_q, ext_q;
  logic [DW-1:0]   addr_q, wdata_q;
  logic [BW-1:0]   wstrb_q;
  logic [1:0]      size_q, off_q;
  logic            valid_q, regwrite_q, memtoreg_q, misal_q;
  logic [DW-1:0]   alu_q, mdata_q;
  logic [RW-1:0]   rd_q;

  logic            op_c, misal_c, start_c, trap_c, done_c, store_c;
  logic [1:0]      off_c;
  logic [BW-1:0]   strb_c;
  logic [DW-1:0]   wdata_c, rshift_c, load_c;

  // Decode, stall, next state, store-lane alignment and load extraction.
  always_comb begin
    state_d  = state_q;
    op_c     = valid_i & (MemToReg_i | MemWrite_i);
    off_c    = ALU_Res_i[1:0];
    store_c  = MemWrite_i & ~MemToReg_i;
    case (Size_i)
      2'b00:   misal_c = 1'b0;
      2'b01:   misal_c = off_c[0];
      default: misal_c = |off_c;
    endcase
    start_c  = (state_q == IDLE) & op_c & ~misal_c;
    trap_c   = (state_q == IDLE) & op_c & misal_c;
    done_c   = (state_q == BUSY) & mem_ack_i;
    stall_o  = start_c | ((state_q == BUSY) & ~mem_ack_i);
    if (start_c) state_d = BUSY;
    if (done_c)  state_d = IDLE;

    case (Size_i)
      2'b00: begin
        strb_c  = BW'(4'b0001 << off_c);
        wdata_c = {4{Write_Data_i[7:0]}};
      end
      2'b01: begin
        strb_c  = BW'(4'b0011 << off_c);
        wdata_c = {2{Write_Data_i[15:0]}};
      end
      default: begin
        strb_c  = 4'b1111;
        wdata_c = Write_Data_i;
      end
    endcase
    if (!store_c) strb_c = '0;

    // Read data is extracted with the size/offset latched at request time.
    rshift_c = mem_rdata_i >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_c = ext_q ? {{24{rshift_c[7]}}, rshift_c[7:0]}
                              : {24'b0, rshift_c[7:0]};
      2'b01:   load_c = ext_q ? {{16{rshift_c[15]}}, rshift_c[15:0]}
                              : {16'b0, rshift_c[15:0]};
      default: load_c = rshift_c;
    endcase
  end

  // State, bus registers and MEM/WB register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      ext_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      size_q     <= '0;
      off_q      <= '0;
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      misal_q    <= 1'b0;
      alu_q      <= '0;
      mdata_q    <= '0;
      rd_q       <= '0;
    end else begin
      state_q <= state_d;
      if (start_c) begin
        req_q   <= 1'b1;
        we_q    <= store_c;
        addr_q  <= {ALU_Res_i[31:2], 2'b00};
        wdata_q <= wdata_c;
        wstrb_q <= strb_c;
        size_q  <= Size_i;
        ext_q   <= ExtOp_i;
        off_q   <= off_c;
      end else if (done_c) begin
        req_q   <= 1'b0;
      end

      // A stalled cycle inserts a bubble; data fields keep their old values.
      if (stall_o) begin
        valid_q    <= 1'b0;
        regwrite_q <= 1'b0;
        memtoreg_q <= 1'b0;
        misal_q    <= 1'b0;
      end else begin
        valid_q    <= valid_i;
        rd_q       <= RdAddr_i;
        alu_q      <= ALU_Res_i;
        regwrite_q <= RegWrite_i & ~trap_c;
        memtoreg_q <= MemToReg_i & ~trap_c;
        misal_q    <= trap_c;
        mdata_q    <= (done_c & ~we_q) ? load_c : '0;
      end
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;
  assign valid_o     = valid_q;
  assign RegWrite_o  = regwrite_q;
  assign MemToReg_o  = memtoreg_q;
  assign ALU_Res_o   = alu_q;
  assign Mem_Data_o  = mdata_q;
  assign RdAddr_o    = rd_q;
  assign misalign_o  = misal_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed vector table, reset corner cases,
// and random transactions checked against a byte-lane reference model.
module tb_mem_access_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] ALU_Res_i, Write_Data_i, mem_rdata_i;
  logic [4:0]  RdAddr_i;
  logic        MemToReg_i, MemWrite_i, RegWrite_i, ExtOp_i, mem_ack_i;
  logic [1:0]  Size_i;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        valid_o, RegWrite_o, MemToReg_o, misalign_o;
  logic [31:0] ALU_Res_o, Mem_Data_o;
  logic [4:0]  RdAddr_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  mem_access_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
    .ALU_Res_i(ALU_Res_i), .Write_Data_i(Write_Data_i), .RdAddr_i(RdAddr_i),
    .MemToReg_i(MemToReg_i), .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i),
    .ExtOp_i(ExtOp_i), .Size_i(Size_i), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .valid_o(valid_o), .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o),
    .ALU_Res_o(ALU_Res_o), .Mem_Data_o(Mem_Data_o), .RdAddr_o(RdAddr_o),
    .misalign_o(misalign_o)
  );

  typedef struct {
    logic [31:0] alu, wd, rdata;
    logic [4:0]  rd;
    logic        m2r, mw, rw, ext;
    logic [1:0]  size;
    int          delay;
  } in_t;

  typedef struct {
    logic        bus, we, misal, rw, m2r;
    logic [31:0] addr, wdata, mdata;
    logic [3:0]  wstrb;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] wd,
                              input logic [31:0] rdata, input logic [4:0] rd,
                              input logic m2r, input logic mw, input logic rw,
                              input logic ext, input logic [1:0] size, input int delay,
                              input logic bus, input logic [31:0] addr,
                              input logic [3:0] strb, input logic [31:0] wdat,
                              input logic [31:0] mdat, input logic mis,
                              input logic erw, input logic em2r);
    vec_t v;
    v.i.alu = alu; v.i.wd = wd; v.i.rdata = rdata; v.i.rd = rd;
    v.i.m2r = m2r; v.i.mw = mw; v.i.rw = rw; v.i.ext = ext;
    v.i.size = size; v.i.delay = delay;
    v.e.bus = bus; v.e.we = mw; v.e.addr = addr; v.e.wstrb = strb;
    v.e.wdata = wdat; v.e.mdata = mdat; v.e.misal = mis;
    v.e.rw = erw; v.e.m2r = em2r;
    return v;
  endfunction

  // Reference model: byte counts and lane arithmetic.
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int a,
                                           input logic [1:0] s, input logic ext);
    logic [31:0] v = '0;
    int n = nbytes(s);
    for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(a+i) +: 8];
    if (ext && n < 4 && v[8*n-1])
      for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
    return v;
  endfunction

  function automatic exp_t ref_model(input in_t v);
    exp_t e;
    int n = nbytes(v.size);
    int a = int'(v.alu[1:0]);
    logic mem = v.m2r | v.mw;
    e.misal = mem && ((a % n) != 0);
    e.bus   = mem && !e.misal;
    e.we    = v.mw && !v.m2r;
    e.addr  = v.alu & 32'hFFFF_FFFC;
    e.rw    = e.misal ? 1'b0 : v.rw;
    e.m2r   = e.misal ? 1'b0 : v.m2r;
    e.mdata = (e.bus && v.m2r) ? ref_load(v.rdata, a, v.size, v.ext) : 32'h0;
    e.wstrb = '0;
    e.wdata = '0;
    for (int i = 0; i < 4; i++) begin
      e.wstrb[i]       = e.we && (i >= a) && (i < a + n);
      e.wdata[8*i +: 8] = v.wd[8*(i % n) +: 8];
    end
    return e;
  endfunction

  task automatic idle_inputs();
    valid_i = 1'b0; ALU_Res_i = '0; Write_Data_i = '0; RdAddr_i = '0;
    MemToReg_i = 1'b0; MemWrite_i = 1'b0; RegWrite_i = 1'b0; ExtOp_i = 1'b0;
    Size_i = 2'b00; mem_ack_i = 1'b0; mem_rdata_i = '0;
  endtask

  task automatic check_wb(input string t, input in_t v, input exp_t e);
    check({t, "_valid"},  32'(valid_o),    32'd1);
    check({t, "_rd"},     32'(RdAddr_o),   32'(v.rd));
    check({t, "_alu"},    ALU_Res_o,       v.alu);
    check({t, "_rw"},     32'(RegWrite_o), 32'(e.rw));
    check({t, "_m2r"},    32'(MemToReg_o), 32'(e.m2r));
    check({t, "_misal"},  32'(misalign_o), 32'(e.misal));
    if (!e.misal) check({t, "_mdata"}, Mem_Data_o, e.mdata);
  endtask

  // Called just after a clock edge; leaves time just after a later edge.
  task automatic run_op(input string t, input in_t v, input exp_t e);
    int stalls = 0;
    int bubbles = 0;
    valid_i = 1'b1; ALU_Res_i = v.alu; Write_Data_i = v.wd; RdAddr_i = v.rd;
    MemToReg_i = v.m2r; MemWrite_i = v.mw; RegWrite_i = v.rw; ExtOp_i = v.ext;
    Size_i = v.size; mem_ack_i = 1'b0; mem_rdata_i = $urandom;
    @(negedge clk_i);
    check({t, "_req_idle"}, 32'(mem_req_o), 32'd0);
    if (!e.bus) begin
      check({t, "_nostall"}, 32'(stall_o), 32'd0);
      @(posedge clk_i); #1;
      check({t, "_noreq"}, 32'(mem_req_o), 32'd0);
      check_wb(t, v, e);
    end else begin
      if (stall_o) stalls++;
      @(posedge clk_i); #1;
      if (!valid_o) bubbles++;
      check({t, "_req"},   32'(mem_req_o),   32'd1);
      check({t, "_addr"},  mem_addr_o,       e.addr);
      check({t, "_we"},    32'(mem_we_o),    32'(e.we));
      check({t, "_wstrb"}, 32'(mem_wstrb_o), 32'(e.wstrb));
      if (e.we) check({t, "_wdata"}, mem_wdata_o, e.wdata);
      for (int k = 0; k < v.delay; k++) begin
        @(negedge clk_i);
        if (stall_o) stalls++;
        @(posedge clk_i); #1;
        if (!valid_o) bubbles++;
        check({t, "_hold_req"},  32'(mem_req_o), 32'd1);
        check({t, "_hold_addr"}, mem_addr_o,     e.addr);
      end
      mem_ack_i = 1'b1; mem_rdata_i = v.rdata;
      @(negedge clk_i);
      check({t, "_stall_ack"}, 32'(stall_o), 32'd0);
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0; mem_rdata_i = $urandom;
      check({t, "_stalls"},  32'(stalls),    32'(v.delay + 1));
      check({t, "_bubbles"}, 32'(bubbles),   32'(v.delay + 1));
      check({t, "_req_drop"}, 32'(mem_req_o), 32'd0);
      check_wb(t, v, e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end

  initial begin
    vec_t tbl[13];
    in_t  ri;
    exp_t re;
    int   kind;

    tbl[0]  = mk(32'h103, 32'h0, 32'h80AABBCC, 5'd3, 1,0,1,1, 2'b00, 0,
                 1, 32'h100, 4'h0, 32'h0, 32'hFFFFFF80, 0, 1, 1);
    tbl[1]  = mk(32'h103, 32'h0, 32'h80AABBCC, 5'd4, 1,0,1,0, 2'b00, 0,
                 1, 32'h100, 4'h0, 32'h0, 32'h00000080, 0, 1, 1);
    tbl[2]  = mk(32'h202, 32'h12345678, 32'h0, 5'd0, 0,1,0,0, 2'b01, 0,
                 1, 32'h200, 4'b1100, 32'h56785678, 32'h0, 0, 0, 0);
    tbl[3]  = mk(32'h40, 32'h0, 32'hDEADBEEF, 5'd9, 1,0,1,0, 2'b10, 3,
                 1, 32'h40, 4'h0, 32'h0, 32'hDEADBEEF, 0, 1, 1);
    tbl[4]  = mk(32'h6, 32'h0, 32'h0, 5'd10, 1,0,1,1, 2'b10, 0,
                 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 0, 0);
    tbl[5]  = mk(32'hCAFEF00D, 32'h0, 32'h0, 5'd7, 0,0,1,0, 2'b10, 0,
                 0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 1, 0);
    tbl[6]  = mk(32'h102, 32'h0, 32'h80011234, 5'd11, 1,0,1,1, 2'b01, 1,
                 1, 32'h100, 4'h0, 32'h0, 32'hFFFF8001, 0, 1, 1);
    tbl[7]  = mk(32'h301, 32'h000000AB, 32'h0, 5'd0, 0,1,0,0, 2'b00, 2,
                 1, 32'h300, 4'b0010, 32'hABABABAB, 32'h0, 0, 0, 0);
    tbl[8]  = mk(32'h3, 32'h11111111, 32'h0, 5'd0, 0,1,0,0, 2'b10, 0,
                 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 0, 0);
    tbl[9]  = mk(32'h3, 32'h0, 32'h0, 5'd12, 1,0,1,1, 2'b01, 0,
                 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 0, 0);
    tbl[10] = mk(32'h2, 32'h0, 32'h00FF0000, 5'd1, 1,0,1,0, 2'b00, 0,
                 1, 32'h0, 4'h0, 32'h0, 32'h000000FF, 0, 1, 1);
    tbl[11] = mk(32'h10, 32'h0, 32'h11223344, 5'd13, 1,0,1,1, 2'b11, 0,
                 1, 32'h10, 4'h0, 32'h0, 32'h11223344, 0, 1, 1);
    tbl[12] = mk(32'h44, 32'hA5A50F0F, 32'h0, 5'd0, 0,1,0,0, 2'b10, 0,
                 1, 32'h44, 4'b1111, 32'hA5A50F0F, 32'h0, 0, 0, 0);

    // Reset while EX/MEM holds an aligned load.
    idle_inputs();
    rst_i = 1'b0;
    valid_i = 1'b1; MemToReg_i = 1'b1; RegWrite_i = 1'b1; ALU_Res_i = 32'h100;
    Size_i = 2'b10; RdAddr_i = 5'd5;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_req",   32'(mem_req_o),   32'd0);
    check("rst_we",    32'(mem_we_o),    32'd0);
    check("rst_addr",  mem_addr_o,       32'd0);
    check("rst_wdata", mem_wdata_o,      32'd0);
    check("rst_wstrb", 32'(mem_wstrb_o), 32'd0);
    check("rst_valid", 32'(valid_o),     32'd0);
    check("rst_rw",    32'(RegWrite_o),  32'd0);
    check("rst_m2r",   32'(MemToReg_o),  32'd0);
    check("rst_alu",   ALU_Res_o,        32'd0);
    check("rst_mdata", Mem_Data_o,       32'd0);
    check("rst_rd",    32'(RdAddr_o),    32'd0);
    check("rst_misal", 32'(misalign_o),  32'd0);
    idle_inputs();
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    for (int i = 0; i < 13; i++) run_op($sformatf("vec%0d", i), tbl[i].i, tbl[i].e);

    // Reset during BUSY, then a stray ack.
    idle_inputs();
    valid_i = 1'b1; MemToReg_i = 1'b1; RegWrite_i = 1'b1; ALU_Res_i = 32'h80;
    Size_i = 2'b10; RdAddr_i = 5'd6;
    @(posedge clk_i); #1;
    check("rb_req", 32'(mem_req_o), 32'd1);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("rb_req_drop", 32'(mem_req_o), 32'd0);
    check("rb_valid",    32'(valid_o),   32'd0);
    rst_i = 1'b1;
    idle_inputs();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h5555AAAA;
    @(negedge clk_i);
    check("rb_ack_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    check("rb_ack_req",   32'(mem_req_o),  32'd0);
    check("rb_ack_valid", 32'(valid_o),    32'd0);
    check("rb_ack_rw",    32'(RegWrite_o), 32'd0);
    check("rb_ack_mdata", Mem_Data_o,      32'd0);
    @(negedge clk_i);
    check("rb_idle_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;

    // Random back-to-back traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      kind     = int'($urandom_range(0, 2));
      ri.alu   = $urandom;
      ri.wd    = $urandom;
      ri.rdata = $urandom;
      ri.rd    = 5'($urandom);
      ri.ext   = 1'($urandom);
      ri.size  = 2'($urandom);
      ri.delay = int'($urandom_range(0, 4));
      ri.m2r   = (kind == 0);
      ri.mw    = (kind == 1);
      ri.rw    = (kind == 0) ? 1'b1 : (kind == 1) ? 1'b0 : 1'($urandom);
      if ($urandom_range(0, 1) == 0) ri.alu[1:0] = 2'b00;
      re = ref_model(ri);
      run_op($sformatf("rnd%0d", n), ri, re);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the five-stage pipeline, directly downstream of the EX/MEM pipeline register and including the MEM/WB register. It turns load/store control from EX/MEM into requests on a single-outstanding req/ack data-memory bus. It aligns store data and byte strobes, extracts and extends load data, and stalls the upstream pipeline until the memory acknowledges. Its registered outputs feed the write-back stage and the forwarding unit.

## Interface
- Parameters: none; data and address are fixed at 32 bits.
- Clock and reset: one clock, `clk_i`. Reset `rst_i` is synchronous and active-low.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-low reset.
- `valid_i`  in  1  EX/MEM holds a live instruction.
- `ALU_Res_i`  in  32  effective address, or result for non-memory ops.
- `Write_Data_i`  in  32  store data, right-justified.
- `RdAddr_i`  in  5  destination register.
- `MemToReg_i`, `MemWrite_i`, `RegWrite_i`, `ExtOp_i`  in  1 each  load, store, register write, sign-extend (1) / zero-extend (0).
- `Size_i`  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- `stall_o`  out  1  combinational; EX/MEM and earlier stages must hold while it is high.
- `mem_req_o`, `mem_we_o`  out  1 each  bus request, write enable.
- `mem_addr_o`  out  32  word-aligned address, `{ALU_Res_i[31:2],2'b00}`.
- `mem_wdata_o`  out  32  lane-replicated store data.
- `mem_wstrb_o`  out  4  byte strobes.
- `mem_rdata_i`  in  32  read data, valid with ack.
- `mem_ack_i`  in  1  one-cycle completion pulse.
- `valid_o`, `RegWrite_o`, `MemToReg_o`  out  1 each  MEM/WB control.
- `ALU_Res_o`, `Mem_Data_o`  out  32 each  MEM/WB data.
- `RdAddr_o`  out  5  MEM/WB destination register.
- `misalign_o`  out  1  MEM/WB flag: access was misaligned.

## Operation
- Memory op: `op = valid_i & (MemToReg_i | MemWrite_i)`.
- Misaligned: half with `addr[0]=1`, or word with `addr[1:0]!=0`.
- FSM states: IDLE, BUSY.
- IDLE → BUSY: on `op & aligned`. Latch address, we, wdata, wstrb, size and ExtOp into bus registers, and assert `mem_req_o` from the next cycle.
- BUSY → IDLE: on `mem_ack_i`. Capture the shifted and extended read data.
- BUSY with no ack: stay in BUSY; all bus outputs are held stable.
- `mem_ack_i` received in IDLE is ignored.
- Stall: `stall_o = (IDLE & op & aligned) | (BUSY & ~mem_ack_i)`.
- Store lanes (`a = addr[1:0]`):
  - byte: strobe `0001<<a`, data `{4{wd[7:0]}}`.
  - half: strobe `0011<<a`, data `{2{wd[15:0]}}`.
  - word: strobe `1111`, data `wd`.
- Loads: `mem_we_o=0`, `mem_wstrb_o=0000`. Shift data as `rdata >> (8*a)`, then extend from bit 7 (byte) or bit 15 (half) when ExtOp=1, else zero-fill.
- MEM/WB update on each edge:
  - While `stall_o=1`: load a bubble (`valid_o=0`, `RegWrite_o=0`, `MemToReg_o=0`, `misalign_o=0`). Data outputs hold their previous values.
  - Otherwise: load the upstream fields.
  - `Mem_Data_o` gets the captured load data, or 0 for non-loads.
- Misaligned op:
  - No bus request and no stall.
  - MEM/WB gets `valid_o=1`, `misalign_o=1`, `RegWrite_o=0`, `MemToReg_o=0`.
- Stores always pass `RegWrite_o` through as given (the decoder drives 0).

## Timing
- Reset (edge with `rst_i=0`):
  - state IDLE.
  - `mem_req_o`, `mem_we_o`, `mem_wstrb_o`, `mem_addr_o`, `mem_wdata_o` = 0.
  - all MEM/WB outputs = 0.
  - `stall_o` is combinational, so it is 0 after reset whenever `valid_i=0`.
- Reset during BUSY: the request drops at that edge, and any later ack for it is ignored.
- Load in EX/MEM during cycle T, ack in T+1 (minimum):
  - `stall_o=1` in T only.
  - `mem_req_o=1` in T+1.
  - `valid_o=1` with load data from the edge ending T+1.
  - Total: one bubble.
- Ack arriving N cycles after the request: N+1 stall cycles and N+1 bubbles.
- Non-memory op: zero stall; MEM/WB loads at the next edge.
- Back-to-back memory ops: the second is seen in IDLE in the cycle after the ack, so `mem_req_o` drops for at least one cycle between requests.

## Test plan
- Reset with `valid_i=1` held → all outputs 0, and state IDLE after release.
- Load byte, addr 0x103, ExtOp=1, ack one cycle after req with rdata 0x80AA_BBCC → `mem_addr_o=0x100`, one bubble, then `Mem_Data_o=0xFFFF_FF80`, `RegWrite_o=1`. Repeat with ExtOp=0 → `0x0000_0080`.
- Store half, addr 0x202, data 0x1234_5678 → `mem_wstrb_o=1100`, `mem_wdata_o=0x5678_5678`, `mem_we_o=1`.
- Load word with ack delayed 3 cycles → `stall_o` high 4 cycles, 4 bubbles, then `Mem_Data_o` equals the acked rdata.
- Word load at addr 0x006 → no `mem_req_o`, `stall_o=0`, MEM/WB gets `misalign_o=1`, `RegWrite_o=0`.
- Reset asserted during BUSY, then a stray ack → `mem_req_o=0` after the reset edge, ack ignored, no MEM/WB update.
